// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int TAG_W = 24;
  localparam int IDX_W = 4;
  localparam int OFF_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_WDONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WS_NONE = 2'b00,
    WS_BYTE = 2'b01,
    WS_HALF = 2'b10,
    WS_WORD = 2'b11
  } wsize_e;

endpackage

// File: rtl/dcache_store_align.sv
// Store lane steering, byte enables and misalignment detection for one CPU access.
module dcache_store_align
  import dcache_pkg::*;
(
  input  logic        rd_i,
  input  logic [1:0]  wsize_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        store_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  always_comb begin
    store_o    = (wsize_i != WS_NONE);
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    data_o     = wdata_i;
    case (wsize_e'(wsize_i))
      WS_BYTE: begin
        be_o   = 4'b0001 << addr_i;
        data_o = {4{wdata_i[7:0]}};
      end
      WS_HALF: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        data_o     = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      WS_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_i;
      end
      // no store: only a word load can be misaligned
      default: misalign_o = rd_i & (|addr_i);
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, read-allocate, write-through, no-write-allocate data cache.
module dcache
  import dcache_pkg::*;
#(
  parameter int NLINES = 1 << IDX_W,
  parameter int WORDS  = 1 << (OFF_W - 2)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic [1:0]  cpu_wsize,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int IB = $clog2(NLINES);
  localparam int WB = $clog2(WORDS);
  localparam int OB = WB + 2;
  localparam int TL = OB + IB;
  localparam int TB = 32 - TL;
  localparam logic [WB-1:0] LAST = WB'(WORDS - 1);

  state_e          state_q, state_d;
  logic [WB-1:0]   cnt_q, cnt_d;
  logic [31:2]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [NLINES-1:0] valid_q;
  logic [TB-1:0]   tag_q  [NLINES];
  logic [31:0]     data_q [NLINES][WORDS];

  logic [TB-1:0] tag_a, tag_h;
  logic [IB-1:0] idx_a, idx_h;
  logic [WB-1:0] wrd_a;
  logic          store, mis, hit, wr_hit;
  logic          read_miss, st_go, last_ack;
  logic [3:0]    al_be;
  logic [31:0]   al_data;

  assign tag_a = cpu_addr[31:TL];
  assign idx_a = cpu_addr[OB +: IB];
  assign wrd_a = cpu_addr[2 +: WB];
  assign tag_h = addr_q[31:TL];
  assign idx_h = addr_q[OB +: IB];

  dcache_store_align u_align (
    .rd_i       (cpu_rd),
    .wsize_i    (cpu_wsize),
    .addr_i     (cpu_addr[1:0]),
    .wdata_i    (cpu_wdata),
    .store_o    (store),
    .misalign_o (mis),
    .be_o       (al_be),
    .data_o     (al_data)
  );

  assign hit       = valid_q[idx_a] & (tag_q[idx_a] == tag_a);
  assign wr_hit    = valid_q[idx_h] & (tag_q[idx_h] == tag_h);
  // a store outranks a simultaneous load; misaligned accesses do nothing
  assign st_go     = store & ~mis;
  assign read_miss = cpu_rd & ~store & ~mis & ~hit;
  assign last_ack  = (state_q == S_REFILL) & mem_ack & (cnt_q == LAST);
  assign misalign  = mis;
  assign cpu_rdata = (cpu_rd & ~store & ~mis & hit) ? data_q[idx_a][wrd_a] : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (st_go) begin
          state_d = S_WRITE;
        end else if (read_miss) begin
          state_d = S_REFILL;
          cnt_d   = '0;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_IDLE;
        end
      end
      S_WRITE:  if (mem_ack) state_d = S_WDONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    stall     = 1'b0;
    case (state_q)
      S_IDLE: stall = read_miss | st_go;
      S_REFILL: begin
        mem_req  = 1'b1;
        stall    = 1'b1;
        mem_addr = {addr_q[31:OB], cnt_q, 2'b00};
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        stall     = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        mem_be    = be_q;
      end
      default: ;
    endcase
  end

  // The request is captured on every idle cycle so it stays frozen once a transaction starts.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      addr_q  <= cpu_addr[31:2];
      wdata_q <= al_data;
      be_q    <= al_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if ((state_q == S_IDLE) && !st_go && read_miss) begin
      valid_q[idx_a] <= 1'b0;
    end else if (last_ack) begin
      valid_q[idx_h] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && (state_q == S_REFILL) && mem_ack) begin
      data_q[idx_h][cnt_q] <= mem_rdata;
      if (cnt_q == LAST) tag_q[idx_h] <= tag_h;
    end
    if (reset && (state_q == S_WRITE) && mem_ack && wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b]) data_q[idx_h][addr_q[2 +: WB]][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a bus-level memory and cache-contents model.
module tb_dcache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_rd = 1'b0;
  logic [1:0]  cpu_wsize = 2'b00;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        stall, misalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dcache #(.NLINES(16), .WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wsize (cpu_wsize),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int ack_dly = 0;

  // model state: memory contents, which lines are cached, refill progress
  logic [31:0] mem_m [logic [31:0]];
  bit   [15:0] mvalid;
  logic [23:0] mtag [16];
  int          beats = 0;
  logic [31:0] hs_addr, hs_wdata;
  logic [3:0]  hs_be;
  logic        hs_we;

  logic [31:0] seen[$];
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_m.exists(w)) return mem_m[w];
    return {w[15:0] ^ 16'hBEEF, w[15:0]};
  endfunction

  function automatic logic exp_mis(input logic rd, input logic [1:0] ws, input logic [31:0] a);
    case (ws)
      2'd1:    return 1'b0;
      2'd2:    return a[0];
      2'd3:    return a[1:0] != 2'b00;
      default: return rd && (a[1:0] != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] ws, input logic [1:0] lo);
    case (ws)
      2'd1:    return 4'(1 << lo);
      2'd2:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] ws, input logic [31:0] d);
    case (ws)
      2'd1:    return {4{d[7:0]}};
      2'd2:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  // Memory responder: acks after ack_dly idle request cycles, applies accepted beats to the model.
  initial begin
    int wc;
    logic [31:0] w;
    wc = 0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        mvalid = '0;
        beats  = 0;
      end else if (mem_ack) begin
        if (hs_we) begin
          w = memrd(hs_addr);
          for (int b = 0; b < 4; b++)
            if (hs_be[b]) w[8*b +: 8] = hs_wdata[8*b +: 8];
          mem_m[{hs_addr[31:2], 2'b00}] = w;
        end else begin
          beats++;
          if (beats == 4) begin
            mvalid[hs_addr[7:4]] = 1'b1;
            mtag[hs_addr[7:4]]   = hs_addr[31:8];
            beats = 0;
          end
        end
      end
      #2;
      if (mem_req && wc >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = memrd(mem_addr);
        hs_addr   = mem_addr;
        hs_we     = mem_we;
        hs_be     = mem_be;
        hs_wdata  = mem_wdata;
        wc        = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wc        = mem_req ? wc + 1 : 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [1:0] b2;
    forever begin
      @(negedge clk);
      if (chk_en && reset) begin
        chk("misalign", misalign, exp_mis(cpu_rd, cpu_wsize, cpu_addr));
        chk("rdata", cpu_rdata,
            (cpu_rd && cpu_wsize == 2'b00 && !exp_mis(cpu_rd, cpu_wsize, cpu_addr) && mhit(cpu_addr))
            ? memrd(cpu_addr) : 32'h0);
        if (misalign) begin
          chk("mis_noreq", mem_req, 1'b0);
          chk("mis_nostall", stall, 1'b0);
        end
        if (mem_req) chk("req_stall", stall, 1'b1);
        if (mem_req && !mem_we) begin
          b2 = beats[1:0];
          chk("refill_addr", mem_addr, {cpu_addr[31:4], b2, 2'b00});
        end
        if (mem_req && mem_we) begin
          chk("wr_addr", mem_addr, {cpu_addr[31:2], 2'b00});
          chk("wr_be", mem_be, exp_be(cpu_wsize, cpu_addr[1:0]));
          chk("wr_data", mem_wdata, exp_wd(cpu_wsize, cpu_wdata));
        end
      end
    end
  end

  task automatic apply(input logic rd, input logic [1:0] ws, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cpu_rd = rd; cpu_wsize = ws; cpu_addr = a; cpu_wdata = d;
  endtask

  // Follows one memory transaction; returns at the first negedge after mem_req falls.
  task automatic wait_txn(output int n, output int ns);
    n = 0; ns = 0;
    seen.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n == 0) begin
          seen_be = mem_be;
          seen_wd = mem_wdata;
        end
        seen.push_back(mem_addr);
        n++;
        if (stall) ns++;
      end else if (n > 0) begin
        return;
      end
    end
    tests++; fails++;
    $display("FAIL txn_timeout: got no completed transaction within 60 cycles, expected one");
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ns;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk_en = 1'b1;

    // read miss with back-to-back acks
    apply(1'b1, 2'b00, 32'h124, 32'h0);
    @(negedge clk);
    chk("miss_stall", stall, 1'b1);
    chk("miss_idle_req", mem_req, 1'b0);
    wait_txn(n, ns);
    chk("refill_beats", n, 4);
    chk("refill_stall_cyc", ns, 4);
    for (int i = 0; i < 4; i++) chk("refill_seq", seen_at(i), 32'h120 + 32'(4 * i));
    chk("after_fill_stall", stall, 1'b0);
    chk("after_fill_rdata", cpu_rdata, 32'hBFCB_0124);

    // hit on the same line
    apply(1'b1, 2'b00, 32'h128, 32'h0);
    @(negedge clk);
    chk("hit_stall", stall, 1'b0);
    chk("hit_req", mem_req, 1'b0);
    chk("hit_rdata", cpu_rdata, 32'hBFC7_0128);
    @(negedge clk);
    chk("hit_req2", mem_req, 1'b0);

    // byte store hitting the cached line
    apply(1'b0, 2'b01, 32'h123, 32'h0000_00AB);
    @(negedge clk);
    chk("sb_stall", stall, 1'b1);
    wait_txn(n, ns);
    chk("sb_beats", n, 1);
    chk("sb_be", seen_be, 4'b1000);
    chk("sb_wdata", seen_wd, 32'hABAB_ABAB);
    chk("sb_addr", seen_at(0), 32'h120);
    chk("sb_wdone_stall", stall, 1'b0);
    apply(1'b1, 2'b00, 32'h120, 32'h0);
    @(negedge clk);
    chk("sb_reread", cpu_rdata, 32'hABCF_0120);

    // half store with a concurrent load: store wins
    apply(1'b1, 2'b10, 32'h12A, 32'h0000_CAFE);
    @(negedge clk);
    chk("sh_stall", stall, 1'b1);
    chk("sh_rdata", cpu_rdata, 32'h0);
    wait_txn(n, ns);
    chk("sh_be", seen_be, 4'b1100);
    chk("sh_wdata", seen_wd, 32'hCAFE_CAFE);
    chk("sh_addr", seen_at(0), 32'h128);
    apply(1'b1, 2'b00, 32'h128, 32'h0);
    @(negedge clk);
    chk("sh_reread", cpu_rdata, 32'hCAFE_0128);

    // misaligned half store and word load
    apply(1'b0, 2'b10, 32'h201, 32'h0000_1234);
    @(negedge clk);
    chk("mis_h_flag", misalign, 1'b1);
    chk("mis_h_stall", stall, 1'b0);
    chk("mis_h_req", mem_req, 1'b0);
    @(negedge clk);
    chk("mis_h_req2", mem_req, 1'b0);
    apply(1'b1, 2'b00, 32'h126, 32'h0);
    @(negedge clk);
    chk("mis_lw_flag", misalign, 1'b1);
    chk("mis_lw_rdata", cpu_rdata, 32'h0);

    // reset in the middle of a refill
    apply(1'b1, 2'b00, 32'h300, 32'h0);
    @(negedge clk);
    chk("rr_stall", stall, 1'b1);
    @(negedge clk);
    chk("rr_beat0", mem_addr, 32'h300);
    @(negedge clk);
    chk("rr_beat1", mem_addr, 32'h304);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rr_beat2", mem_addr, 32'h308);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rr_req_after", mem_req, 1'b0);
    chk("rr_stall_after", stall, 1'b1);
    wait_txn(n, ns);
    chk("rr_beats", n, 4);
    chk("rr_first", seen_at(0), 32'h300);
    chk("rr_rdata", cpu_rdata, 32'hBDEF_0300);

    // uncached word store with slow ack, then read misses
    ack_dly = 3;
    apply(1'b0, 2'b11, 32'h400, 32'h1234_5678);
    @(negedge clk);
    chk("sw_stall", stall, 1'b1);
    wait_txn(n, ns);
    chk("sw_req_cyc", n, 4);
    chk("sw_stall_cyc", ns, 4);
    chk("sw_be", seen_be, 4'b1111);
    chk("sw_wdata", seen_wd, 32'h1234_5678);
    chk("sw_wdone_stall", stall, 1'b0);
    chk("sw_wdone_req", mem_req, 1'b0);
    ack_dly = 0;
    apply(1'b1, 2'b00, 32'h400, 32'h0);
    @(negedge clk);
    chk("sw_noalloc", stall, 1'b1);
    wait_txn(n, ns);
    chk("sw_fill_beats", n, 4);
    chk("sw_fill_rdata", cpu_rdata, 32'h1234_5678);

    apply(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
